// File: rtl/coprocessador_sel_param.sv
// rtl/coprocessador_sel_param.sv - one-hot selector for N_ALG resize algorithms with buffered output
module coprocessador_sel_param #(
  parameter int PW         = 8,
  parameter int N_ALG      = 4,
  parameter int DIM_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 20
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [N_ALG-1:0]    mode,
  input  logic [DIM_W-1:0]    largura_in,
  input  logic [DIM_W-1:0]    altura_in,
  input  logic [PW-1:0]       pixel_in,
  input  logic                pixel_in_valid,
  output logic                pixel_in_ready,
  output logic [N_ALG-1:0]    alg_start,
  input  logic [N_ALG*PW-1:0] alg_pixel,
  input  logic [N_ALG-1:0]    alg_valid,
  input  logic [N_ALG-1:0]    alg_done,
  input  logic [N_ALG-1:0]    alg_ready,
  output logic [PW-1:0]       pixel_out,
  output logic                pixel_out_valid,
  input  logic                pixel_out_ready,
  output logic                processing_done,
  output logic                busy,
  output logic                mode_error,
  output logic                overflow,
  output logic [CNT_W-1:0]    out_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [N_ALG-1:0] MODE_ONE = 1;
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [AW:0]      CNT_ONE  = 1;
  localparam logic [AW:0]      DEPTH_V  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] OUT_ONE  = 1;

  logic [1:0]       state, state_nx;
  logic [N_ALG-1:0] sel;

  logic [PW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             fifo_full, fifo_empty;

  logic             mode_zero, mode_onehot, mode_multi, legal_start;
  logic             sel_valid, sel_done, sel_ready;
  logic [PW-1:0]    sel_pixel;
  logic             push_req, do_push, drop, pop;
  logic [PW-1:0]    push_data;

  // Dimensions reach the algorithms on external wiring; nothing here consumes them.
  logic unused_dims;
  assign unused_dims = ^{largura_in, altura_in};

  assign mode_zero   = (mode == '0);
  assign mode_onehot = !mode_zero && ((mode & (mode - MODE_ONE)) == '0);
  assign mode_multi  = !mode_zero && !mode_onehot;
  assign legal_start = (state == S_IDLE) && start && mode_onehot;

  always_comb begin
    sel_valid = 1'b0;
    sel_done  = 1'b0;
    sel_ready = 1'b0;
    sel_pixel = '0;
    for (int k = 0; k < N_ALG; k++) begin
      if (sel[k]) begin
        sel_valid = sel_valid | alg_valid[k];
        sel_done  = sel_done  | alg_done[k];
        sel_ready = sel_ready | alg_ready[k];
        sel_pixel = sel_pixel | alg_pixel[k*PW +: PW];
      end
    end
  end

  assign fifo_empty      = (fifo_cnt == '0);
  assign fifo_full       = (fifo_cnt == DEPTH_V);
  assign pixel_out_valid = !fifo_empty;
  assign pixel_out       = fifo_empty ? '0 : mem[rd_ptr];
  assign pop             = pixel_out_valid && pixel_out_ready;

  // Source of FIFO writes: raw input in bypass, the latched algorithm otherwise.
  always_comb begin
    push_req       = 1'b0;
    push_data      = sel_pixel;
    pixel_in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode_zero) begin
          push_req       = pixel_in_valid;
          push_data      = pixel_in;
          pixel_in_ready = !fifo_full;
        end
      end
      S_RUN: begin
        push_req       = sel_valid;
        pixel_in_ready = sel_ready;
      end
      S_DRAIN: push_req = sel_valid;
      default: ;
    endcase
  end

  assign do_push = push_req && (!fifo_full || pop);
  assign drop    = push_req && fifo_full && !pop;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (legal_start) state_nx = S_RUN;
      S_RUN:   if (sel_done) state_nx = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy            = (state == S_RUN) || (state == S_DRAIN);
  assign processing_done = (state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      sel        <= '0;
      alg_start  <= '0;
      mode_error <= 1'b0;
      overflow   <= 1'b0;
      out_count  <= '0;
    end else begin
      state     <= state_nx;
      alg_start <= legal_start ? mode : '0;
      if (legal_start) begin
        sel        <= mode;
        mode_error <= 1'b0;
        overflow   <= 1'b0;
        out_count  <= '0;
      end else begin
        if ((state == S_IDLE) && start && mode_multi)
          mode_error <= 1'b1;
        if (drop)
          overflow <= 1'b1;
        if (pop && (out_count != '1))
          out_count <= out_count + OUT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: doc/coprocessador_sel_param.md
Name: coprocessador_sel_param

Overview:
Parametrised successor to the four-algorithm image coprocessor selector. It drives N_ALG resize algorithm instances (replication, nearest in/out, block mean, ...) from a one-hot mode that is latched on start, so it cannot change mid-frame. The output path is buffered through a FIFO with valid/ready backpressure. The block tracks frame state with an FSM, counts output pixels and flags illegal modes and FIFO overflow. It sits between the top-level control/memory path and the algorithm instances.

Parameters:
PW, 8, pixel width in bits
N_ALG, 4, number of attached algorithms (one-hot mode width)
DIM_W, 10, width of largura/altura
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 20, output pixel counter width

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
start  in  1  frame start request
mode  in  N_ALG  one-hot algorithm select; all-zero = bypass
largura_in  in  DIM_W  input width, forwarded to algorithms
altura_in  in  DIM_W  input height, forwarded to algorithms
pixel_in  in  PW  input pixel, fanned to all algorithms externally
pixel_in_valid  in  1  input pixel valid (bypass mode only)
pixel_in_ready  out  1  input ready, muxed from the selected algorithm
alg_start  out  N_ALG  one-cycle start pulse to the selected algorithm only
alg_pixel  in  N_ALG*PW  flattened algorithm outputs, alg k at [k*PW +: PW]
alg_valid  in  N_ALG  per-algorithm output valid
alg_done  in  N_ALG  per-algorithm done
alg_ready  in  N_ALG  per-algorithm input ready
pixel_out  out  PW  FIFO head pixel
pixel_out_valid  out  1  FIFO non-empty
pixel_out_ready  in  1  downstream accept
processing_done  out  1  one-cycle pulse at end of frame
busy  out  1  high in RUN or DRAIN
mode_error  out  1  sticky illegal-mode flag
overflow  out  1  sticky FIFO overflow flag
out_count  out  CNT_W  output handshakes since last start

Behaviour:
- Reset (async, resetn=0): FSM=IDLE; sel=0; FIFO emptied. alg_start, processing_done, busy, mode_error, overflow, out_count and pixel_out_valid are 0; pixel_out=0. Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE with start=1:
  - legal one-hot mode (exactly one bit set, within N_ALG): latch sel=mode; pulse alg_start=mode for one cycle; clear out_count, mode_error and overflow; go to RUN.
  - multi-hot mode: set mode_error; stay in IDLE; no alg_start.
  - mode=0: no state change.
- IDLE with mode=0 (bypass): pixel_in/pixel_in_valid feed the FIFO; pixel_in_ready = FIFO not full; no done pulse.
- IDLE with a legal mode and no start: pixel_in_ready=0.
- RUN:
  - pixel_in_ready = alg_ready[sel]; FIFO write = alg_valid[sel] with data from slice sel.
  - alg_done[sel]=1 -> DRAIN. A valid pixel arriving in the same cycle is still written.
  - start and mode changes are ignored.
- DRAIN: pixel_in_ready=0; remaining alg_valid[sel] pixels are still written; FIFO empty -> DONE.
- DONE: processing_done=1 for exactly one cycle; next state IDLE.
- busy = (state==RUN or DRAIN).
- FIFO:
  - first-word-fall-through; write at cycle t -> pixel_out_valid at t+1.
  - pop on pixel_out_valid && pixel_out_ready.
  - simultaneous push and pop while full succeeds, count unchanged.
  - push while full without pop: the pixel is dropped, overflow set (sticky until next legal start); no FIFO state corruption.
  - pointers wrap modulo FIFO_DEPTH.
- out_count increments on each output handshake and saturates at all-ones.
- Algorithms other than sel are ignored: their valid and done inputs have no effect.

Test Plan:
- Reset then start, mode=4'b0001: alg_start=0001 for exactly 1 cycle, busy=1. Alg0 emits 16 valids with pixel_out_ready=1: 16 outputs with identical data, each 1 cycle after its valid. Then alg_done[0] -> DRAIN -> processing_done pulse 1 cycle; out_count=16.
- Start with mode=4'b0110: mode_error=1, FSM stays IDLE, alg_start=0. A following start with 4'b1000 clears mode_error and goes to RUN.
- RUN with sel=0010, pixel_out_ready=0, 6 valids from alg1 (DEPTH=4): pixel_out_valid=1, 4 entries held, overflow=1. Releasing ready drains exactly 4 pixels, in order.
- Mode switched to 0100 and start pulsed mid-RUN: no effect; only alg1 outputs appear; alg2 valid/done ignored.
- Bypass (mode=0): pixel_in 0xA5 with valid=1 -> pixel_out=0xA5 the next cycle. Ready low for 4 cycles -> pixel_in_ready=0 once 4 entries are held.
- resetn pulsed low mid-DRAIN: all outputs 0 immediately, no processing_done, FIFO empty after release.
